// File: rtl/alu_seq.sv
// Multi-cycle ALU: registered single-cycle integer ops, iterative unsigned multiply and,
// when ALU_DIV_EN is defined, an iterative restoring unsigned divide.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alusel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_res,
    output logic [WIDTH-1:0] alu_hi,
    output logic             alu_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] SelAdd  = 4'b0001;
    localparam logic [3:0] SelSub  = 4'b0011;
    localparam logic [3:0] SelAnd  = 4'b0111;
    localparam logic [3:0] SelOr   = 4'b1111;
    localparam logic [3:0] SelSlt  = 4'b1110;
    localparam logic [3:0] SelSll  = 4'b1100;
    localparam logic [3:0] SelSrl  = 4'b1000;
    localparam logic [3:0] SelMulu = 4'b0100;
`ifdef ALU_DIV_EN
    localparam logic [3:0] SelDivu = 4'b0110;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul} state_e;
`endif

    state_e           stateQ, stateD;
    logic [CW-1:0]    cntQ, cntD;
    logic [WIDTH-1:0] accQ, accD;    // product high half / partial remainder
    logic [WIDTH-1:0] lowQ, lowD;    // multiplier shifting into product low half / dividend->quotient
    logic [WIDTH-1:0] opBQ, opBD;    // multiplicand / divisor
    logic [WIDTH-1:0] resQ, resD;
    logic [WIDTH-1:0] hiQ, hiD;
    logic             zeroQ, zeroD;
    logic             doneQ, doneD;

    logic [WIDTH-1:0] opRes, opHi;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulLow;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]   divTrial;
    logic             divGe;
    logic [WIDTH-1:0] divRem;
    logic [WIDTH-1:0] divQuo;
`endif

    // Single-cycle result from the live inputs, loaded only on accept.
    always_comb begin
        opRes = '0;
        opHi  = '0;
        case (alusel)
            SelAdd: opRes = opA + opB;
            SelSub: opRes = opA - opB;
            SelAnd: opRes = opA & opB;
            SelOr:  opRes = opA | opB;
            SelSlt: opRes = {{(WIDTH-1){1'b0}}, ($signed(opA) < $signed(opB))};
            SelSll: opRes = opB << opA[SHW-1:0];
            SelSrl: opRes = opB >> opA[SHW-1:0];
`ifdef ALU_DIV_EN
            // Only reached with opB == 0; nonzero divisors go to StDiv.
            SelDivu: begin
                opRes = '1;
                opHi  = opA;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        mulSum = {1'b0, accQ} + (lowQ[0] ? {1'b0, opBQ} : '0);
        mulLow = {mulSum[0], lowQ[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        divTrial = {accQ, lowQ[WIDTH-1]};
        divGe    = (divTrial >= {1'b0, opBQ});
        divRem   = WIDTH'(divGe ? divTrial - {1'b0, opBQ} : divTrial);
        divQuo   = {lowQ[WIDTH-2:0], divGe};
`endif

        stateD = stateQ;
        cntD   = cntQ;
        accD   = accQ;
        lowD   = lowQ;
        opBD   = opBQ;
        resD   = resQ;
        hiD    = hiQ;
        zeroD  = zeroQ;
        doneD  = 1'b0;

        case (stateQ)
            StIdle: begin
                if (start) begin
                    if (alusel == SelMulu) begin
                        stateD = StMul;
                        cntD   = CW'(WIDTH);
                        accD   = '0;
                        lowD   = opA;
                        opBD   = opB;
`ifdef ALU_DIV_EN
                    end else if (alusel == SelDivu && opB != '0) begin
                        stateD = StDiv;
                        cntD   = CW'(WIDTH);
                        accD   = '0;
                        lowD   = opA;
                        opBD   = opB;
`endif
                    end else begin
                        resD  = opRes;
                        hiD   = opHi;
                        zeroD = (opRes == '0);
                        doneD = 1'b1;
                    end
                end
            end
            StMul: begin
                accD = mulSum[WIDTH:1];
                lowD = mulLow;
                cntD = cntQ - CW'(1);
                if (cntQ == CW'(1)) begin
                    stateD = StIdle;
                    resD   = mulLow;
                    hiD    = mulSum[WIDTH:1];
                    zeroD  = (mulLow == '0);
                    doneD  = 1'b1;
                end
            end
`ifdef ALU_DIV_EN
            StDiv: begin
                accD = divRem;
                lowD = divQuo;
                cntD = cntQ - CW'(1);
                if (cntQ == CW'(1)) begin
                    stateD = StIdle;
                    resD   = divQuo;
                    hiD    = divRem;
                    zeroD  = (divQuo == '0);
                    doneD  = 1'b1;
                end
            end
`endif
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            accQ   <= '0;
            lowQ   <= '0;
            opBQ   <= '0;
            resQ   <= '0;
            hiQ    <= '0;
            zeroQ  <= 1'b1;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            accQ   <= accD;
            lowQ   <= lowD;
            opBQ   <= opBD;
            resQ   <= resD;
            hiQ    <= hiD;
            zeroQ  <= zeroD;
            doneQ  <= doneD;
        end
    end

    assign busy     = (stateQ != StIdle);
    assign done     = doneQ;
    assign alu_res  = resQ;
    assign alu_hi   = hiQ;
    assign alu_zero = zeroQ;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32; define ALU_DIV_EN to cover the divider.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alusel = 4'b0000;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        busy, done, alu_zero;
    logic [31:0] alu_res, alu_hi;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .alusel  (alusel),
        .opA     (opA),
        .opB     (opB),
        .busy    (busy),
        .done    (done),
        .alu_res (alu_res),
        .alu_hi  (alu_hi),
        .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a request for one edge; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        alusel = sel;
        opA    = a;
        opB    = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        opA    = 32'hDEAD_BEEF;
        opB    = 32'h1234_5678;
    endtask

    // Bounded wait for done; cycles counts edges after the accept edge.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b1;
        alusel = 4'b0001;
        opA    = 32'd5;
        opB    = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if ({alu_res, alu_hi, alu_zero, busy, done} !== {32'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset: res=%h hi=%h zero=%b busy=%b done=%b, required 0 0 1 0 0",
                     alu_res, alu_hi, alu_zero, busy, done);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || alu_res !== 32'd0) begin
            fails++;
            $display("FAIL reset_idle: done=%b res=%h, required 0 0", done, alu_res);
        end
    endtask

    task automatic test_single_ops;
        logic [3:0]  sel [9] = '{4'b1110, 4'b0011, 4'b1100, 4'b1000, 4'b0001,
                                 4'b0111, 4'b1111, 4'b0000, 4'b1110};
        logic [31:0] a   [9] = '{32'hFFFF_FFFF, 32'd5, 32'h23, 32'hFFFF_FFE4, 32'hFFFF_FFFF,
                                 32'hF0F0_1234, 32'hF000_0000, 32'd7, 32'd1};
        logic [31:0] b   [9] = '{32'h1, 32'd5, 32'h1, 32'h8000_0000, 32'd1,
                                 32'h0FF0_FFFF, 32'h0000_000F, 32'd9, 32'hFFFF_FFFF};
        logic [31:0] exp [9] = '{32'h1, 32'h0, 32'h8, 32'h0800_0000, 32'h0,
                                 32'h00F0_1234, 32'hF000_000F, 32'h0, 32'h0};
        for (int i = 0; i < 9; i++) begin
            issue(sel[i], a[i], b[i]);
            tests++;
            if (done !== 1'b1 || busy !== 1'b0 || alu_res !== exp[i] || alu_hi !== 32'd0 ||
                alu_zero !== (exp[i] == 32'd0)) begin
                fails++;
                $display("FAIL single_op[%0d] sel=%b: done=%b busy=%b res=%h hi=%h zero=%b, required 1 0 %h 0 %b",
                         i, sel[i], done, busy, alu_res, alu_hi, alu_zero, exp[i], exp[i] == 32'd0);
            end
            @(posedge clk);
            #1;
            tests++;
            if (done !== 1'b0 || alu_res !== exp[i]) begin
                fails++;
                $display("FAIL single_hold[%0d]: done=%b res=%h, required 0 %h", i, done, alu_res, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start  = 1'b1;
        alusel = 4'b0001;
        opA    = 32'd1;
        opB    = 32'd2;
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || alu_res !== 32'd3) begin
            fails++;
            $display("FAIL b2b_first: done=%b res=%h, required 1 3", done, alu_res);
        end
        @(negedge clk);
        opA = 32'd3;
        opB = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests++;
        if (done !== 1'b1 || alu_res !== 32'd7) begin
            fails++;
            $display("FAIL b2b_second: done=%b res=%h, required 1 7", done, alu_res);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || alu_res !== 32'd7) begin
            fails++;
            $display("FAIL b2b_after: done=%b res=%h, required 0 7", done, alu_res);
        end
    endtask

    task automatic test_mul_max;
        int busyBad = 0;
        issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL mul_start: busy=%b done=%b, required 1 0", busy, done);
        end
        for (int i = 1; i < 32; i++) begin
            if (i == 5) begin
                start  = 1'b1;
                alusel = 4'b0001;
                opA    = 32'd1;
                opB    = 32'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) busyBad++;
        end
        tests++;
        if (busyBad != 0) begin
            fails++;
            $display("FAIL mul_busy: %0d cycles without busy=1/done=0, required 0", busyBad);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || alu_hi !== 32'hFFFF_FFFE ||
            alu_res !== 32'h0000_0001 || alu_zero !== 1'b0) begin
            fails++;
            $display("FAIL mul_max: done=%b busy=%b hi=%h res=%h zero=%b, required 1 0 fffffffe 00000001 0",
                     done, busy, alu_hi, alu_res, alu_zero);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || alu_res !== 32'h1) begin
            fails++;
            $display("FAIL mul_ignored_start: done=%b res=%h, required 0 00000001", done, alu_res);
        end
    endtask

    task automatic test_mul_values;
        logic [31:0] a   [3] = '{32'd6, 32'h1234_5678, 32'h0};
        logic [31:0] b   [3] = '{32'd7, 32'h10, 32'hABCD_0001};
        logic [31:0] eHi [3] = '{32'd0, 32'h1, 32'h0};
        logic [31:0] eLo [3] = '{32'd42, 32'h2345_6780, 32'h0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            issue(4'b0100, a[i], b[i]);
            wait_done(cyc);
            tests++;
            if (cyc != 32 || alu_hi !== eHi[i] || alu_res !== eLo[i] ||
                alu_zero !== (eLo[i] == 32'd0)) begin
                fails++;
                $display("FAIL mul[%0d]: cycles=%0d hi=%h res=%h zero=%b, required 32 %h %h %b",
                         i, cyc, alu_hi, alu_res, alu_zero, eHi[i], eLo[i], eLo[i] == 32'd0);
            end
        end
    endtask

    task automatic test_div;
        int cyc;
`ifdef ALU_DIV_EN
        issue(4'b0110, 32'd100, 32'd7);
        wait_done(cyc);
        tests++;
        if (cyc != 32 || alu_res !== 32'd14 || alu_hi !== 32'd2) begin
            fails++;
            $display("FAIL div_100_7: cycles=%0d q=%h r=%h, required 32 0000000e 00000002",
                     cyc, alu_res, alu_hi);
        end
        issue(4'b0110, 32'hFFFF_FFFF, 32'h0001_0000);
        wait_done(cyc);
        tests++;
        if (cyc != 32 || alu_res !== 32'h0000_FFFF || alu_hi !== 32'h0000_FFFF) begin
            fails++;
            $display("FAIL div_big: cycles=%0d q=%h r=%h, required 32 0000ffff 0000ffff",
                     cyc, alu_res, alu_hi);
        end
        issue(4'b0110, 32'd9, 32'd0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || alu_res !== 32'hFFFF_FFFF || alu_hi !== 32'd9) begin
            fails++;
            $display("FAIL div_by_zero: done=%b busy=%b q=%h r=%h, required 1 0 ffffffff 00000009",
                     done, busy, alu_res, alu_hi);
        end
`else
        issue(4'b0001, 32'd2, 32'd3);
        issue(4'b0110, 32'd100, 32'd7);
        wait_done(cyc);
        tests++;
        if (cyc != 0 || busy !== 1'b0 || alu_res !== 32'd0 || alu_hi !== 32'd0 || alu_zero !== 1'b1) begin
            fails++;
            $display("FAIL divu_disabled: cycles=%0d busy=%b res=%h hi=%h zero=%b, required 0 0 0 0 1",
                     cyc, busy, alu_res, alu_hi, alu_zero);
        end
`endif
    endtask

    task automatic test_reset_mid_mul;
        int sawDone = 0;
        issue(4'b0001, 32'd40, 32'd2);
        issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_res !== 32'd0 || alu_hi !== 32'd0 ||
            alu_zero !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_mul: busy=%b done=%b res=%h hi=%h zero=%b, required 0 0 0 0 1",
                     busy, done, alu_res, alu_hi, alu_zero);
        end
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) sawDone++;
        end
        tests++;
        if (sawDone != 0) begin
            fails++;
            $display("FAIL reset_abort: %0d cycles with done/busy after reset, required 0", sawDone);
        end
        issue(4'b0001, 32'd10, 32'd20);
        tests++;
        if (done !== 1'b1 || alu_res !== 32'd30 || alu_zero !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_add: done=%b res=%h zero=%b, required 1 0000001e 0",
                     done, alu_res, alu_zero);
        end
    endtask

    initial begin
        test_reset;
        test_single_ops;
        test_back_to_back;
        test_mul_max;
        test_mul_values;
        test_div;
        test_reset_mid_mul;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the datapath ALU. It keeps the single-cycle integer operations and their `alusel` encodings, and adds an iterative unsigned multiplier and an optional iterative unsigned divider. Every operation uses a start/busy/done handshake, and all results are registered. It sits in the execute stage; the controller holds the pipeline while `busy` is high.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived, not overridden).

Ports:
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; accepted on a rising edge when `start`=1 and `busy`=0.
- `alusel`  input  4  operation select, sampled at accept.
- `opA`  input  WIDTH  operand A; for shifts, `opA[SHW-1:0]` is the shift amount.
- `opB`  input  WIDTH  operand B; for shifts, the value to shift.
- `busy`  output  1  a multi-cycle operation is in progress.
- `done`  output  1  one-cycle pulse; the result is valid from this cycle onward.
- `alu_res`  output  WIDTH  result, product low half, or quotient.
- `alu_hi`  output  WIDTH  product high half or remainder; 0 for all other operations.
- `alu_zero`  output  1  registered, equals `alu_res == 0`.

## Operation
`alusel` encodings:
- ADD `0001`: `opA + opB`, modulo 2^WIDTH.
- SUB `0011`: `opA - opB`, modulo 2^WIDTH.
- AND `0111`: bitwise AND.
- OR `1111`: bitwise OR.
- SLT `1110`: 1 if `opA < opB` as a two's-complement signed compare, else 0.
- SLL `1100`: `opB` shifted left logical by `opA[SHW-1:0]`.
- SRL `1000`: `opB` shifted right logical by `opA[SHW-1:0]`.
- MULTU `0100`: unsigned 2·WIDTH-bit product; `{alu_hi, alu_res}` = product.
- DIVU `0110`: unsigned divide; `alu_res` = quotient, `alu_hi` = remainder. Present only with `ALU_DIV_EN`.
- Any other code: `alu_res` = 0, `alu_hi` = 0, completes as a single-cycle operation.

Shift amount:
- Only `opA[SHW-1:0]` is used; upper bits are ignored.
- A shift never reaches WIDTH or more.

State machine: IDLE, MUL, DIV.
- IDLE + accept of a single-cycle op: load `alu_res`, `alu_hi`, `alu_zero`; pulse `done`; stay in IDLE.
- IDLE + accept of MULTU: latch the operands, clear the accumulator, counter := WIDTH, go to MUL, `busy`=1.
- MUL: one shift-add step per cycle, counter decrements.
  - When the counter reaches 0: load results, pulse `done`, clear `busy`, return to IDLE.
- IDLE + accept of DIVU with `opB` ≠ 0: latch the operands, counter := WIDTH, go to DIV.
  - DIV: one restoring step per cycle, with the same completion rule as MUL.
- DIVU with `opB` = 0: single-cycle; quotient = all ones, remainder = `opA`. DIV is not entered.

Handshake rules:
- `start` while `busy`=1 is ignored; it is not queued.
- Operands and `alusel` may change freely after accept.
- Results hold until the next accepted operation completes.

Reset:
- `rst`=1 at any edge forces IDLE, aborts any iteration and discards its partial result.
- Reset output values: `alu_res`=0, `alu_hi`=0, `alu_zero`=1, `busy`=0, `done`=0.
- `rst` has priority over `start` in the same cycle.

## Timing
Latency is counted in edges after the accept edge k; results become visible after the stated edge.
- Single-cycle ops: results and `done`=1 after edge k+1 − 1, i.e. visible in the cycle immediately following edge k.
- MULTU and DIVU: `busy`=1 from after edge k through edge k+WIDTH−1.
  - After edge k+WIDTH: results valid, `done`=1, `busy`=0.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, because `busy` is already 0.
  - Single-cycle ops therefore sustain one result per clock.
- `alu_zero` updates on the same edge as `alu_res`.
- `done` is never high for more than one cycle per operation.

## Configuration
- `ALU_DIV_EN` defined: divider datapath and DIV state are compiled in; DIVU behaves as specified above.
- `ALU_DIV_EN` undefined:
  - No divider hardware and no DIV state.
  - `0110` is treated as an unsupported code: `alu_res`=0, `alu_hi`=0, single-cycle `done`.

## Test plan
All scenarios use WIDTH=32.
- Reset then idle: after `rst`, `alu_res`=0, `alu_hi`=0, `alu_zero`=1, `busy`=0, `done`=0.
- Single-cycle ops:
  - SLT `0xFFFFFFFF` vs `0x00000001` → 1.
  - SUB `5 − 5` → 0 with `alu_zero`=1.
  - SLL `opB`=1, `opA`=`0x23` → `0x00000008` (shamt 3).
  - Each op gives `done` one cycle after start.
- Back-to-back ADDs: 1+2, then 3+4 on consecutive cycles → 3, then 7; `done` high two consecutive cycles.
- MULTU `0xFFFFFFFF × 0xFFFFFFFF` → `alu_hi`=`0xFFFFFFFE`, `alu_res`=`0x00000001` after 32 cycles.
  - `busy` stays high for 31 cycles.
  - A `start` issued mid-operation is ignored.
- With `ALU_DIV_EN`:
  - DIVU 100/7 → quotient 14, remainder 2 after 32 cycles.
  - DIVU 9/0 → quotient `0xFFFFFFFF`, remainder 9 after 1 cycle.
- Without `ALU_DIV_EN`: DIVU 100/7 → `alu_res`=0, `alu_hi`=0, `done` after 1 cycle.
- Reset mid-MULTU: assert `rst` at iteration 10 → `busy`=0, `alu_res`=0, no `done` pulse, next ADD works normally.
